// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward RX frame buffer. Whole frames are written speculatively
// and become visible to the read side only when their last byte arrives with
// tuser=0. Bad frames and frames that overflow the buffer are rolled back.
//
// Handshake: a byte moves on the master side in every cycle where
// m_tvalid_o && m_tready_i is high at the rising clock edge. Once raised,
// m_tvalid_o stays high with m_tdata_o/m_tlast_o unchanged until that
// handshake. The slave side has no ready, so every s_tvalid_i byte is
// consumed (stored or discarded) in the cycle it is presented.
module eth_rx_frame_fifo #(
    parameter int DEPTH = 4096,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [7:0]             s_tdata_i,
    input  logic                   s_tvalid_i,
    input  logic                   s_tlast_i,
    input  logic                   s_tuser_i,
    output logic [7:0]             m_tdata_o,
    output logic                   m_tvalid_o,
    input  logic                   m_tready_i,
    output logic                   m_tlast_o,
    output logic                   m_tuser_o,
    input  logic                   clear_cnt_i,
    output logic [CNT_W-1:0]       frames_ok_o,
    output logic [CNT_W-1:0]       drop_err_o,
    output logic [CNT_W-1:0]       drop_ovf_o,
    output logic [$clog2(DEPTH):0] frames_pending_o,
    output logic                   dbg_wr_state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [0:0] {
        RECV    = 1'b0,
        DISCARD = 1'b1
    } wr_state_t;

    wr_state_t       state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]   rd_ptr_q;
    logic [8:0]      mem [DEPTH];
    logic            mem_we;
    logic            full;
    logic            readable;
    logic            inc_ok, inc_err, inc_ovf;
    logic [8:0]      out_word_q;
    logic            out_valid_q;
    logic            out_fire;
    logic            load;
    logic [CNT_W-1:0] cnt_ok_q, cnt_err_q, cnt_ovf_q;
    logic [PW-1:0]   pending_q;

    // The output register's byte has already left memory, so rd_ptr counts it.
    assign full     = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign readable = rd_ptr_q != commit_ptr_q;
    assign out_fire = out_valid_q && m_tready_i;
    assign load     = (!out_valid_q || out_fire) && readable;

    // Write FSM state and speculative/commit pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RECV;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
        end
    end

    // Next-state logic: store, commit, roll back on error, or drop on overflow.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        mem_we       = 1'b0;
        inc_ok       = 1'b0;
        inc_err      = 1'b0;
        inc_ovf      = 1'b0;
        case (state_q)
            RECV: begin
                if (s_tvalid_i) begin
                    if (!full) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (s_tlast_i) begin
                            if (!s_tuser_i) begin
                                commit_ptr_d = wr_ptr_q + 1'b1;
                                inc_ok       = 1'b1;
                            end else begin
                                wr_ptr_d = commit_ptr_q;
                                inc_err  = 1'b1;
                            end
                        end
                    end else begin
                        wr_ptr_d = commit_ptr_q;
                        inc_ovf  = 1'b1;
                        if (!s_tlast_i) begin
                            state_d = DISCARD;
                        end
                    end
                end
            end
            DISCARD: begin
                if (s_tvalid_i && s_tlast_i) begin
                    state_d = RECV;
                end
            end
            default: state_d = RECV;
        endcase
    end

    // Frame storage: synchronous write, combinational read.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= {s_tlast_i, s_tdata_i};
        end
    end

    // Output register: refill on the same edge as a handshake so frames stream.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            rd_ptr_q    <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_word_q  <= mem[rd_ptr_q[AW-1:0]];
            rd_ptr_q    <= rd_ptr_q + 1'b1;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

    // Committed frames not yet fully handed downstream.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            case ({inc_ok, out_fire && out_word_q[8]})
                2'b10:   pending_q <= pending_q + 1'b1;
                2'b01:   pending_q <= pending_q - 1'b1;
                default: pending_q <= pending_q;
            endcase
        end
    end

    // Saturating statistics; a clear beats a same-cycle increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_ok_q  <= '0;
            cnt_err_q <= '0;
            cnt_ovf_q <= '0;
        end else if (clear_cnt_i) begin
            cnt_ok_q  <= '0;
            cnt_err_q <= '0;
            cnt_ovf_q <= '0;
        end else begin
            if (inc_ok && (cnt_ok_q != '1)) begin
                cnt_ok_q <= cnt_ok_q + 1'b1;
            end
            if (inc_err && (cnt_err_q != '1)) begin
                cnt_err_q <= cnt_err_q + 1'b1;
            end
            if (inc_ovf && (cnt_ovf_q != '1)) begin
                cnt_ovf_q <= cnt_ovf_q + 1'b1;
            end
        end
    end

    assign m_tvalid_o       = out_valid_q;
    assign m_tdata_o        = out_word_q[7:0];
    assign m_tlast_o        = out_word_q[8];
    assign m_tuser_o        = 1'b0;
    assign frames_ok_o      = cnt_ok_q;
    assign drop_err_o       = cnt_err_q;
    assign drop_ovf_o       = cnt_ovf_q;
    assign frames_pending_o = pending_q;
    assign dbg_wr_state_o   = state_q;

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Bench for eth_rx_frame_fifo: frame-level reference model with an expected
// byte queue, directed scenarios plus randomized frames and backpressure.
module tb_eth_rx_frame_fifo;

    localparam int DEPTH = 64;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] s_tdata_i = '0;
    logic       s_tvalid_i = 1'b0;
    logic       s_tlast_i = 1'b0;
    logic       s_tuser_i = 1'b0;
    logic [7:0] m_tdata_o;
    logic       m_tvalid_o;
    logic       m_tready_i = 1'b1;
    logic       m_tlast_o;
    logic       m_tuser_o;
    logic       clear_cnt_i = 1'b0;
    logic [CNT_W-1:0] frames_ok_o, drop_err_o, drop_ovf_o;
    logic [$clog2(DEPTH):0] frames_pending_o;
    logic       dbg_wr_state_o;

    initial forever #5 clk_i = ~clk_i;

    eth_rx_frame_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_tdata_i(s_tdata_i), .s_tvalid_i(s_tvalid_i),
        .s_tlast_i(s_tlast_i), .s_tuser_i(s_tuser_i),
        .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o),
        .m_tready_i(m_tready_i), .m_tlast_o(m_tlast_o), .m_tuser_o(m_tuser_o),
        .clear_cnt_i(clear_cnt_i),
        .frames_ok_o(frames_ok_o), .drop_err_o(drop_err_o),
        .drop_ovf_o(drop_ovf_o), .frames_pending_o(frames_pending_o),
        .dbg_wr_state_o(dbg_wr_state_o)
    );

    // ---------------- model state / scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;
    logic [8:0] exp_q[$];
    int m_ok = 0, m_err = 0, m_ovf = 0, m_pending = 0;
    int ready_mode = 0;   // 0 ready, 1 stalled, 2 toggle, 3 random
    bit prev_stall = 1'b0;
    logic [8:0] prev_word = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic check_stats(input string tag);
        check_eq({tag, "_ok"},      frames_ok_o,      m_ok);
        check_eq({tag, "_err"},     drop_err_o,       m_err);
        check_eq({tag, "_ovf"},     drop_ovf_o,       m_ovf);
        check_eq({tag, "_pending"}, frames_pending_o, m_pending);
    endtask

    // ---------------- downstream ready driver ----------------
    initial forever begin
        @(posedge clk_i);
        #1;
        case (ready_mode)
            0: m_tready_i = 1'b1;
            1: m_tready_i = 1'b0;
            2: m_tready_i = ~m_tready_i;
            default: m_tready_i = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- output monitor ----------------
    initial forever begin
        @(negedge clk_i);
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", m_tvalid_o, 1);
                check_eq("hold_word", {m_tlast_o, m_tdata_o}, prev_word);
            end
            if (m_tvalid_o && m_tready_i) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out_qsize", exp_q.size(), 1);
                end else begin
                    logic [8:0] w;
                    w = exp_q.pop_front();
                    check_eq("out_word", {m_tlast_o, m_tdata_o}, w);
                    check_eq("out_tuser", m_tuser_o, 0);
                    if (w[8]) m_pending--;
                end
            end
            prev_stall = m_tvalid_o && !m_tready_i;
            prev_word  = {m_tlast_o, m_tdata_o};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_byte(input logic [7:0] d, input logic last, input logic user);
        s_tdata_i  = d;
        s_tvalid_i = 1'b1;
        s_tlast_i  = last;
        s_tuser_i  = user;
        @(posedge clk_i);
        #1;
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
        s_tuser_i  = 1'b0;
    endtask

    // A frame is accepted when it fits beside everything not yet seen leaving.
    task automatic send_frame(input int len, input bit bad, input int base, input bit gaps);
        bit drop;
        drop = (exp_q.size() + len) > DEPTH;
        for (int i = 0; i < len; i++) begin
            logic last;
            last = (i == len - 1);
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk_i);
                    #1;
                end
            end
            if (last) begin
                if (drop) m_ovf = sat_inc(m_ovf);
                else if (bad) m_err = sat_inc(m_err);
                else begin
                    for (int j = 0; j < len; j++)
                        exp_q.push_back({(j == len - 1), 8'(base + j)});
                    m_ok = sat_inc(m_ok);
                    m_pending++;
                end
            end
            drive_byte(8'(base + i), last, last ? bad : 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic wait_room(input int len);
        int k;
        k = 0;
        while ((exp_q.size() + len > DEPTH) && k < 3000) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        check_eq("room_wait", (exp_q.size() + len <= DEPTH), 1);
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        repeat (4) @(posedge clk_i);
        #1;
        check_eq({tag, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic clear_counters();
        clear_cnt_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_cnt_i = 1'b0;
        m_ok = 0; m_err = 0; m_ovf = 0;
    endtask

    task automatic set_ready(input int mode);
        ready_mode = mode;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_tvalid", m_tvalid_o, 0);
        check_eq("rst_tdata", m_tdata_o, 0);
        check_eq("rst_tlast", m_tlast_o, 0);
        check_eq("rst_tuser", m_tuser_o, 0);
        check_eq("rst_state", dbg_wr_state_o, 0);
        check_stats("rst");
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Good 64-byte frame, latency check on its first byte.
        send_frame(64, 0, 0, 0);
        @(negedge clk_i);
        check_eq("lat_pre_valid", m_tvalid_o, 0);
        @(negedge clk_i);
        check_eq("lat_first_valid", m_tvalid_o, 1);
        check_eq("lat_first_data", m_tdata_o, 0);
        wait_drain("t1");
        check_stats("t1");

        // Bad frame then good frame.
        clear_counters();
        send_frame(60, 1, 8'h80, 0);
        send_frame(64, 0, 8'h40, 0);
        wait_drain("t2");
        check_stats("t2");

        // Overflow while stalled.
        clear_counters();
        set_ready(1);
        send_frame(40, 0, 8'h10, 0);
        send_frame(40, 0, 8'h90, 0);
        check_stats("t3_held");
        check_eq("t3_state", dbg_wr_state_o, 0);
        set_ready(0);
        wait_drain("t3");
        check_stats("t3");

        // Three 1-byte frames, then toggling backpressure.
        clear_counters();
        set_ready(1);
        send_frame(1, 0, 8'hA1, 0);
        send_frame(1, 0, 8'hA2, 0);
        send_frame(1, 0, 8'hA3, 0);
        check_stats("t4_peak");
        ready_mode = 2;
        wait_drain("t4");
        check_stats("t4");

        // Pointer wrap with counter saturation.
        clear_counters();
        set_ready(0);
        for (int f = 0; f < 20; f++) begin
            wait_room(50);
            send_frame(50, 0, f * 7, 0);
        end
        wait_drain("t5");
        check_stats("t5");

        // Randomized frames, errors, gaps and backpressure.
        clear_counters();
        ready_mode = 3;
        for (int f = 0; f < 40; f++) begin
            int len;
            bit bad;
            len = $urandom_range(1, 64);
            bad = ($urandom_range(0, 4) == 0);
            wait_room(len);
            send_frame(len, bad, $urandom_range(0, 255), 1);
        end
        wait_drain("t6");
        check_stats("t6");

        // Clear on the same edge as a commit.
        clear_counters();
        set_ready(0);
        send_frame(5, 0, 8'h60, 0);
        drive_byte(8'h51, 1'b0, 1'b0);
        drive_byte(8'h52, 1'b0, 1'b0);
        exp_q.push_back({1'b0, 8'h51});
        exp_q.push_back({1'b0, 8'h52});
        exp_q.push_back({1'b1, 8'h53});
        m_pending++;
        clear_cnt_i = 1'b1;
        drive_byte(8'h53, 1'b1, 1'b0);
        clear_cnt_i = 1'b0;
        m_ok = 0; m_err = 0; m_ovf = 0;
        check_eq("t7_clr_win", frames_ok_o, m_ok);
        wait_drain("t7");
        check_stats("t7");

        // Reset in the middle of a frame.
        set_ready(1);
        send_frame(10, 0, 8'h20, 0);
        check_stats("t8_pre");
        for (int i = 0; i < 5; i++) drive_byte(8'(8'hC0 + i), 1'b0, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        exp_q.delete();
        m_ok = 0; m_err = 0; m_ovf = 0; m_pending = 0;
        check_eq("t8_rst_tvalid", m_tvalid_o, 0);
        check_eq("t8_rst_tdata", m_tdata_o, 0);
        check_eq("t8_rst_tlast", m_tlast_o, 0);
        check_stats("t8_rst");
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        ready_mode = 0;
        @(posedge clk_i);
        #1;
        send_frame(10, 0, 8'h30, 0);
        wait_drain("t8");
        check_stats("t8");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_fifo.md
Name: eth_rx_frame_fifo

Overview:
- Store-and-forward RX frame buffer directly downstream of the RGMII framing/MAC-filter stage.
- Accepts the filtered byte-wide AXI-Stream RX output, which has no backpressure, and buffers whole frames.
- Discards frames flagged bad (tuser=1 on the last byte) or frames that overflow the buffer, so only complete, good frames are released.
- Releases frames on a byte-wide AXI-Stream master with full tready backpressure, toward the DMA.

Parameters:
DEPTH, 4096, buffer capacity in bytes; power of two, minimum 64
CNT_W, 16, width of the statistics counters

Ports:
clk_i  in  1  single clock (125 MHz RX domain)
rst_i  in  1  asynchronous reset, active-high
s_tdata_i  in  8  RX byte from the framing stage
s_tvalid_i  in  1  byte valid; no tready exists, so every valid byte must be consumed
s_tlast_i  in  1  last byte of frame
s_tuser_i  in  1  error flag, sampled only with s_tlast_i (1 = bad FCS/abort)
m_tdata_o  out  8  output byte
m_tvalid_o  out  1  output valid
m_tready_i  in  1  downstream ready
m_tlast_o  out  1  last byte of output frame
m_tuser_o  out  1  always 0 (only good frames are emitted)
clear_cnt_i  in  1  synchronous clear of the three statistics counters
frames_ok_o  out  CNT_W  frames committed, saturating
drop_err_o  out  CNT_W  frames dropped for tuser=1, saturating
drop_ovf_o  out  CNT_W  frames dropped for overflow, saturating
frames_pending_o  out  log2(DEPTH)+1  committed frames not yet fully read out

Behaviour:
- Storage: DEPTH entries of 9 bits {tlast, tdata}. Combinational read, synchronous write.
- Pointers are log2(DEPTH)+1 bits wide, with an MSB wrap bit: wr_ptr (speculative), commit_ptr, rd_ptr.
- Full when wr_ptr-rd_ptr == DEPTH. Readable when rd_ptr != commit_ptr.
- Write FSM states: RECV, DISCARD. Reset state is RECV.
- RECV, valid byte, not full: write {tlast, tdata} at wr_ptr and increment wr_ptr.
  - If tlast and tuser=0: commit_ptr <= wr_ptr+1; frames_ok +1.
  - If tlast and tuser=1: wr_ptr <= commit_ptr; drop_err +1.
- RECV, valid byte, full:
  - Byte is not stored; wr_ptr <= commit_ptr; drop_ovf +1.
  - If tlast, stay in RECV; otherwise go to DISCARD.
- DISCARD: ignore all bytes. On a valid tlast byte, return to RECV. No counter changes in this state.
- Empty frames cannot occur; a 1-byte frame is legal.
- Output stage: one register holding {tlast, tdata} plus a valid bit.
  - Loads mem[rd_ptr] and increments rd_ptr when (register empty OR m_tvalid_o&&m_tready_i) AND readable.
  - Otherwise the register drops valid on a handshake.
  - Back-to-back frames stream with no bubble.
- Latency: first byte of a frame is on m_tvalid_o one cycle after the edge that sampled its good tlast, provided the output register is free.
- AXIS rules: m_tdata_o and m_tlast_o are stable while m_tvalid_o && !m_tready_i. m_tvalid_o never drops without a handshake.
- frames_pending_o: +1 on commit, -1 on an output handshake with m_tlast_o=1; both in the same cycle leaves it unchanged.
- The read side never reads past commit_ptr. A partial or rejected frame is never visible on the output.
- Counters:
  - Saturate at 2^CNT_W-1.
  - clear_cnt_i zeroes all three counters and wins over a same-cycle increment.
  - clear_cnt_i does not affect frames_pending_o.
- Reset (async assert): all pointers 0, FSM in RECV, output register empty, and all outputs 0 (m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0, m_tuser_o=0, counters 0, frames_pending_o 0).
  - A frame in flight at reset is lost.
  - Bytes arriving after deassert mid-frame are stored as a new frame; the team accepts this.

Test Plan:
- Good 64-byte frame (bytes 0x00..0x3F, tuser=0), m_tready_i=1 -> identical 64 bytes out, m_tlast_o on 0x3F, first m_tvalid_o one cycle after tlast edge, frames_ok_o=1.
- 60-byte frame with tuser=1 on tlast, then good 64-byte frame -> only the 64-byte frame emitted, drop_err_o=1, frames_ok_o=1, no output between the two.
- DEPTH=64, m_tready_i=0: 40-byte good frame then 40-byte frame -> second dropped (drop_ovf_o=1), its remaining bytes ignored until tlast; release tready -> exactly 40 bytes out, frames_pending_o 1->0.
- Three back-to-back 1-byte good frames, m_tready_i toggling 1,0,1,0 -> three outputs each with m_tlast_o=1, data held stable while stalled, frames_pending_o peaks at 3 and returns to 0.
- Pointer wrap: DEPTH=64, stream 20 good 50-byte frames with tready=1 -> all 1000 bytes match in order, no drops, pointers wrap correctly.
- Assert rst_i mid-frame, then a good 10-byte frame -> all outputs and counters 0 during reset; afterwards only the 10-byte frame appears, frames_ok_o=1.
